// File: rtl/prio_pkg.sv
// Shared constants, FSM state encoding and a one-hot helper for the
// 8-input priority service controller.
package prio_pkg;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  // Encoding 2'd3 is never entered; the FSM steers it back to IDLE.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OFFER   = 2'd1,
    SERVICE = 2'd2
  } state_t;

  function automatic logic [N-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] code;
    code = '0;
    code[idx] = 1'b1;
    return code;
  endfunction

endpackage

// File: rtl/prio_sel_8.sv
// Combinational highest-set-bit selector: 8-bit vector to {any, idx}.
// Bit 7 has the highest priority, bit 0 the lowest.
module prio_sel_8 (
  input  logic [7:0] vec,
  output logic       any,
  output logic [2:0] idx
);

  // Ascending scan so the last (highest) set bit found wins.
  always_comb begin
    any = |vec;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (vec[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/prio_service_ctrl.sv
// Consumer end of the 8-input priority interface: sticky pending vector,
// priority pick, valid/ready offer, then hold until the servicer reports done.
module prio_service_ctrl
  import prio_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     out_onehot,
  input  logic             done,
  output logic             busy,
  output logic             idle,
  output logic [N-1:0]     pend
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] held_idx_q, held_idx_d;
  logic [N-1:0]     pend_q, pend_d;
  logic [N-1:0]     clr;
  logic             sel_any;
  logic [IDX_W-1:0] sel_idx;

  prio_sel_8 u_sel (
    .vec (pend_q),
    .any (sel_any),
    .idx (sel_idx)
  );

  // A request arriving in the same cycle as the retire keeps the bit set,
  // so that source is served again rather than lost.
  always_comb begin
    clr = '0;
    if (state_q == SERVICE && done) clr = idx_to_onehot(held_idx_q);
    pend_d = (pend_q & ~clr) | req;
  end

  always_comb begin
    state_d    = state_q;
    held_idx_d = held_idx_q;
    case (state_q)
      IDLE: begin
        if (sel_any) begin
          held_idx_d = sel_idx;
          state_d    = OFFER;
        end
      end
      OFFER: begin
        if (out_ready) state_d = SERVICE;
      end
      SERVICE: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      held_idx_q <= '0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      held_idx_q <= held_idx_d;
      pend_q     <= pend_d;
    end
  end

  // Outputs depend on registered state only, never directly on inputs.
  always_comb begin
    out_valid  = (state_q == OFFER);
    busy       = (state_q == OFFER) || (state_q == SERVICE);
    idle       = (pend_q == '0) && (state_q == IDLE);
    out_idx    = held_idx_q;
    out_onehot = busy ? idx_to_onehot(held_idx_q) : '0;
    pend       = pend_q;
  end

endmodule
